mem_ctrl_arbiter: RTL and testbench



---
 rtl/mem_ctrl_arbiter_pkg.sv | 33 +++
 rtl/mem_ctrl_arbiter_if.sv | 46 ++++
 rtl/mem_ctrl_arbiter_rr_arbiter.sv | 33 +++
 rtl/mem_ctrl_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_ctrl_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and sizing helpers for the mem_ctrl arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_RD   = 2'b01,
        OP_RSVD = 2'b10,
        OP_WR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RELEASE = 2'b10
    } state_e;

    localparam int DEF_WORD_SIZE     = 32;
    localparam int DEF_CL_SIZE_WIDTH = 512;
    localparam int WORDS_PER_LINE    = DEF_CL_SIZE_WIDTH / DEF_WORD_SIZE;
    localparam int WCNT_W            = $clog2(WORDS_PER_LINE + 1);

    // Bits needed to hold every value in 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_arbiter_if
// Description : Requester-side and mem_ctrl-side buses of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_ctrl_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_BITCOUNT = 64,
    parameter int WORD_SIZE     = 32
) ();
    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ-1:0][1:0]               req_op;
    logic [NUM_REQ-1:0][ADDR_BITCOUNT-1:0] req_addr;
    logic [NUM_REQ-1:0][ADDR_BITCOUNT-1:0] req_offset;
    logic [NUM_REQ-1:0][WORD_SIZE-1:0]     req_wdata;
    logic [NUM_REQ-1:0]                    grant;
    logic [NUM_REQ-1:0]                    wr_pull;
    logic [NUM_REQ-1:0]                    rd_valid_out;
    logic [WORD_SIZE-1:0]                  rd_data;
    logic [NUM_REQ-1:0]                    req_done;
    logic [NUM_REQ-1:0]                    req_err;
    logic                                  ctrl_ready;
    logic                                  ctrl_tx_done;
    logic                                  ctrl_rd_valid;
    logic [1:0]                            op;
    logic [ADDR_BITCOUNT-1:0]              raw_address;
    logic [ADDR_BITCOUNT-1:0]              address_offset;
    logic [WORD_SIZE-1:0]                  common_data_bus_read_in;
    logic [WORD_SIZE-1:0]                  common_data_bus_write_out;

    modport master (
        input  req_valid, req_op, req_addr, req_offset, req_wdata,
        input  ctrl_ready, ctrl_tx_done, ctrl_rd_valid, common_data_bus_write_out,
        output grant, wr_pull, rd_valid_out, rd_data, req_done, req_err,
        output op, raw_address, address_offset, common_data_bus_read_in
    );

    modport slave (
        output req_valid, req_op, req_addr, req_offset, req_wdata,
        output ctrl_ready, ctrl_tx_done, ctrl_rd_valid, common_data_bus_write_out,
        input  grant, wr_pull, rd_valid_out, rd_data, req_done, req_err,
        input  op, raw_address, address_offset, common_data_bus_read_in
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick of the first request after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  wire logic [NUM_REQ-1:0]         req,
    input  wire logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic      [NUM_REQ-1:0]         winner,
    output logic                            any
);
    // Two passes: indices above ptr first, then wrap to 0..ptr.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i > int'(ptr))) begin
                winner[i] = 1'b1;
                any       = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i <= int'(ptr))) begin
                winner[i] = 1'b1;
                any       = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_arbiter
// Description : Round-robin sharing of one mem_ctrl between NUM_REQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BITCOUNT  = 64,
    parameter int WORD_SIZE      = 32,
    parameter int CL_SIZE_WIDTH  = 512,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mem_ctrl_arbiter_if.master bus
);
    localparam int WPL    = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int CNT_W  = cnt_width(WPL);
    localparam int WD_W   = cnt_width(TIMEOUT_CYCLES);
    localparam int IDX_W  = $clog2(NUM_REQ);

    state_e                   state_q, state_d;
    op_e                      op_q, op_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]       wr_pull_q, wr_pull_d;
    logic [NUM_REQ-1:0]       req_done_q, req_done_d;
    logic [NUM_REQ-1:0]       req_err_q, req_err_d;
    logic [ADDR_BITCOUNT-1:0] raw_addr_q, raw_addr_d;
    logic [ADDR_BITCOUNT-1:0] addr_off_q, addr_off_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]         wcnt_q, wcnt_d;
    logic [WD_W-1:0]          wd_q, wd_d;

    logic [NUM_REQ-1:0]       eligible;
    logic [NUM_REQ-1:0]       win_oh;
    logic                     win_any;
    logic [IDX_W-1:0]         win_idx;
    op_e                      win_op;
    logic                     busy_rd;
    logic                     busy_wr;

    // A nop is indistinguishable from an absent request.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] && (bus.req_op[i] != OP_NOP);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (eligible),
        .ptr    (ptr_q),
        .winner (win_oh),
        .any    (win_any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign win_op = op_e'(bus.req_op[win_idx]);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        grant_d    = grant_q;
        wr_pull_d  = wr_pull_q;
        req_done_d = '0;
        req_err_d  = '0;
        raw_addr_d = raw_addr_q;
        addr_off_d = addr_off_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        wcnt_d     = wcnt_q;
        wd_d       = wd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ctrl_ready && win_any) begin
                    ptr_d = win_idx;
                    if (win_op == OP_RSVD) begin
                        req_done_d = win_oh;
                        req_err_d  = win_oh;
                    end else begin
                        state_d    = BUSY;
                        op_d       = win_op;
                        grant_d    = win_oh;
                        owner_d    = win_idx;
                        raw_addr_d = bus.req_addr[win_idx];
                        addr_off_d = bus.req_offset[win_idx];
                        wcnt_d     = '0;
                        wd_d       = '0;
                        wr_pull_d  = (win_op == OP_WR) ? win_oh : '0;
                    end
                end
            end
            BUSY: begin
                wd_d = wd_q + WD_W'(1);
                if (|wr_pull_q) begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                    if (wcnt_q == CNT_W'(WPL - 1)) begin
                        wr_pull_d = '0;
                    end
                end
                // tx_done on the watchdog's last cycle is a clean completion.
                if (bus.ctrl_tx_done || (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d    = RELEASE;
                    op_d       = OP_NOP;
                    grant_d    = '0;
                    wr_pull_d  = '0;
                    req_done_d = grant_q;
                    req_err_d  = bus.ctrl_tx_done ? '0 : grant_q;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_NOP;
            grant_q    <= '0;
            wr_pull_q  <= '0;
            req_done_q <= '0;
            req_err_q  <= '0;
            raw_addr_q <= '0;
            addr_off_q <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            owner_q    <= '0;
            wcnt_q     <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            grant_q    <= grant_d;
            wr_pull_q  <= wr_pull_d;
            req_done_q <= req_done_d;
            req_err_q  <= req_err_d;
            raw_addr_q <= raw_addr_d;
            addr_off_q <= addr_off_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            wcnt_q     <= wcnt_d;
            wd_q       <= wd_d;
        end
    end

    assign busy_rd = (state_q == BUSY) && (op_q == OP_RD);
    assign busy_wr = (state_q == BUSY) && (op_q == OP_WR);

    assign bus.grant                   = grant_q;
    assign bus.wr_pull                 = wr_pull_q;
    assign bus.req_done                = req_done_q;
    assign bus.req_err                 = req_err_q;
    assign bus.op                      = op_q;
    assign bus.raw_address             = raw_addr_q;
    assign bus.address_offset          = addr_off_q;
    assign bus.rd_data                 = busy_rd ? bus.common_data_bus_write_out : '0;
    assign bus.rd_valid_out            = (busy_rd && bus.ctrl_rd_valid) ? grant_q : '0;
    assign bus.common_data_bus_read_in = busy_wr ? bus.req_wdata[owner_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl_arbiter
// Description : Directed bench with a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_arbiter;
    localparam int N   = 4;
    localparam int AW  = 64;
    localparam int WS  = 32;
    localparam int CL  = 512;
    localparam int TO  = 64;
    localparam int WPL = CL / WS;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_ctrl_arbiter_if #(.NUM_REQ(N), .ADDR_BITCOUNT(AW), .WORD_SIZE(WS)) bus_if ();

    mem_ctrl_arbiter #(
        .NUM_REQ(N), .ADDR_BITCOUNT(AW), .WORD_SIZE(WS),
        .CL_SIZE_WIDTH(CL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Reference model: owner = -1 means no transaction; m_rel marks the wind-down cycle.
    int           m_owner, m_age, m_pulled, m_ptr;
    logic [1:0]   m_op;
    logic [63:0]  m_addr, m_off;
    bit           m_rel;
    logic [N-1:0] m_done, m_err;

    always @(negedge clk) begin : model
        bit           active, found;
        logic [N-1:0] e_grant, e_pull, e_rdv;
        logic [31:0]  e_rdata, e_wbus;
        int           w;
        if (!rst_n) begin
            m_owner = -1; m_age = 0; m_pulled = 0; m_ptr = N - 1;
            m_op = 2'b00; m_addr = '0; m_off = '0; m_rel = 0;
            m_done = '0; m_err = '0;
        end
        active  = (m_owner >= 0) && !m_rel;
        e_grant = active ? onehot(m_owner) : '0;
        e_pull  = (active && m_op == 2'b11 && m_pulled < WPL) ? onehot(m_owner) : '0;
        e_rdv   = (active && m_op == 2'b01 && bus_if.ctrl_rd_valid) ? onehot(m_owner) : '0;
        e_rdata = (active && m_op == 2'b01) ? bus_if.common_data_bus_write_out : '0;
        e_wbus  = (active && m_op == 2'b11) ? bus_if.req_wdata[m_owner] : '0;
        chk("m_grant", bus_if.grant, e_grant);
        chk("m_op", bus_if.op, active ? m_op : 2'b00);
        chk("m_raw_address", bus_if.raw_address, m_addr);
        chk("m_address_offset", bus_if.address_offset, m_off);
        chk("m_wr_pull", bus_if.wr_pull, e_pull);
        chk("m_rd_valid_out", bus_if.rd_valid_out, e_rdv);
        chk("m_rd_data", bus_if.rd_data, e_rdata);
        chk("m_wbus", bus_if.common_data_bus_read_in, e_wbus);
        chk("m_req_done", bus_if.req_done, m_done);
        chk("m_req_err", bus_if.req_err, m_err);
        if (rst_n) begin
            m_done = '0;
            m_err  = '0;
            if (m_rel) begin
                m_rel   = 0;
                m_owner = -1;
            end else if (active) begin
                m_age++;
                if (e_pull != '0) m_pulled++;
                if (bus_if.ctrl_tx_done || m_age == TO) begin
                    m_rel  = 1;
                    m_done = onehot(m_owner);
                    m_err  = bus_if.ctrl_tx_done ? '0 : onehot(m_owner);
                end
            end else if (bus_if.ctrl_ready) begin
                found = 0;
                for (int j = 1; j <= N; j++) begin
                    w = (m_ptr + j) % N;
                    if (!found && bus_if.req_valid[w] && bus_if.req_op[w] != 2'b00) begin
                        found = 1;
                        m_ptr = w;
                        if (bus_if.req_op[w] == 2'b10) begin
                            m_done = onehot(w);
                            m_err  = onehot(w);
                        end else begin
                            m_owner  = w;
                            m_op     = bus_if.req_op[w];
                            m_addr   = bus_if.req_addr[w];
                            m_off    = bus_if.req_offset[w];
                            m_age    = 0;
                            m_pulled = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int n = 0; n < 20 && idx < 0; n++) begin
            if (bus_if.grant != '0) begin
                for (int i = 0; i < N; i++) if (bus_if.grant[i]) idx = i;
            end else begin
                tick();
            end
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: no grant within 20 cycles");
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL sim_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin : stim
        int beats, pulls, g;
        int order[4];
        rst_n = 1'b0;
        bus_if.req_valid = '0; bus_if.req_op = '0; bus_if.req_addr = '0;
        bus_if.req_offset = '0; bus_if.req_wdata = '0;
        bus_if.ctrl_ready = 1'b1; bus_if.ctrl_tx_done = 1'b0; bus_if.ctrl_rd_valid = 1'b0;
        bus_if.common_data_bus_write_out = '0;
        repeat (3) tick();
        chk("rst_grant", bus_if.grant, 0);
        chk("rst_op", bus_if.op, 0);
        chk("rst_raw_address", bus_if.raw_address, 0);
        rst_n = 1'b1;
        tick();

        // Single read
        bus_if.req_op[0] = 2'b01; bus_if.req_addr[0] = 64'h1000; bus_if.req_offset[0] = 64'h40;
        bus_if.req_valid[0] = 1'b1;
        tick();
        chk("rd_grant", bus_if.grant, 4'b0001);
        chk("rd_op", bus_if.op, 2'b01);
        chk("rd_raw_address", bus_if.raw_address, 64'h1000);
        chk("rd_address_offset", bus_if.address_offset, 64'h40);
        bus_if.req_valid[0] = 1'b0;
        beats = 0;
        for (int k = 0; k < WPL; k++) begin
            bus_if.ctrl_rd_valid = 1'b1;
            bus_if.common_data_bus_write_out = 32'hD000_0000 + k;
            #1;
            if (bus_if.rd_valid_out == 4'b0001 && bus_if.rd_data == 32'hD000_0000 + k) beats++;
            tick();
        end
        bus_if.ctrl_rd_valid = 1'b0;
        bus_if.ctrl_tx_done = 1'b1;
        tick();
        bus_if.ctrl_tx_done = 1'b0;
        chk("rd_beats", beats, 16);
        chk("rd_done", bus_if.req_done, 4'b0001);
        chk("rd_err", bus_if.req_err, 4'b0000);
        chk("rd_op_release", bus_if.op, 2'b00);
        tick();

        // Reserved op
        bus_if.req_op[1] = 2'b10; bus_if.req_valid[1] = 1'b1;
        tick();
        bus_if.req_valid[1] = 1'b0;
        chk("rsvd_grant", bus_if.grant, 0);
        chk("rsvd_op", bus_if.op, 0);
        chk("rsvd_done", bus_if.req_done, 4'b0010);
        chk("rsvd_err", bus_if.req_err, 4'b0010);
        tick();
        chk("rsvd_done_pulse", bus_if.req_done, 0);

        // Write pacing
        bus_if.req_op[2] = 2'b11; bus_if.req_addr[2] = 64'h2000; bus_if.req_offset[2] = 64'h80;
        bus_if.req_wdata[2] = 32'hA0; bus_if.req_valid[2] = 1'b1;
        tick();
        chk("wr_grant", bus_if.grant, 4'b0100);
        chk("wr_op", bus_if.op, 2'b11);
        bus_if.req_valid[2] = 1'b0;
        pulls = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 19) bus_if.ctrl_tx_done = 1'b1;
            if (bus_if.wr_pull[2]) begin
                chk("wr_word", bus_if.common_data_bus_read_in, 32'hA0 + pulls);
                pulls++;
                bus_if.req_wdata[2] = 32'hA0 + pulls;
            end
            tick();
        end
        bus_if.ctrl_tx_done = 1'b0;
        chk("wr_pulls", pulls, 16);
        chk("wr_done", bus_if.req_done, 4'b0100);
        tick();

        // Timeout, then tx_done exactly on the limit cycle
        bus_if.req_op[0] = 2'b01; bus_if.req_valid[0] = 1'b1;
        tick();
        chk("to_grant", bus_if.grant, 4'b0001);
        bus_if.req_valid[0] = 1'b0;
        repeat (TO - 1) tick();
        chk("to_still_busy", bus_if.grant, 4'b0001);
        tick();
        chk("to_grant_clear", bus_if.grant, 0);
        chk("to_done", bus_if.req_done, 4'b0001);
        chk("to_err", bus_if.req_err, 4'b0001);
        tick();
        bus_if.req_valid[0] = 1'b1;
        tick();
        chk("tolim_grant", bus_if.grant, 4'b0001);
        bus_if.req_valid[0] = 1'b0;
        repeat (TO - 1) tick();
        bus_if.ctrl_tx_done = 1'b1;
        tick();
        bus_if.ctrl_tx_done = 1'b0;
        chk("tolim_done", bus_if.req_done, 4'b0001);
        chk("tolim_err", bus_if.req_err, 4'b0000);
        tick();

        // Reset mid-write after 5 words
        bus_if.req_op[2] = 2'b11; bus_if.req_wdata[2] = 32'hB0; bus_if.req_valid[2] = 1'b1;
        tick();
        chk("rstw_grant", bus_if.grant, 4'b0100);
        bus_if.req_valid[2] = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rstw_grant0", bus_if.grant, 0);
        chk("rstw_pull0", bus_if.wr_pull, 0);
        chk("rstw_op0", bus_if.op, 0);
        tick();
        chk("rstw_no_done", bus_if.req_done, 0);
        rst_n = 1'b1;
        tick();

        // Round-robin among 0, 1, 3; requester 2 idle
        bus_if.req_op[0] = 2'b01; bus_if.req_op[1] = 2'b01; bus_if.req_op[3] = 2'b01;
        bus_if.req_valid = 4'b1011;
        for (int r = 0; r < 4; r++) begin
            if (r == 3) bus_if.req_valid[0] = 1'b1;
            wait_grant(g);
            order[r] = g;
            if (g >= 0) bus_if.req_valid[g] = 1'b0;
            bus_if.ctrl_tx_done = 1'b1;
            tick();
            bus_if.ctrl_tx_done = 1'b0;
            tick();
        end
        chk("rr_first", order[0], 0);
        chk("rr_second", order[1], 1);
        chk("rr_third", order[2], 3);
        chk("rr_wrap", order[3], 0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
